// File: rtl/wishbone_if.sv
// Wishbone classic bus as seen by the instruction fetch path (read-only master).
// The master holds cyc/stb/adr stable until the slave returns ack with dat_r valid in that cycle.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr,
    output dat_r, ack
  );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch queue: a Wishbone fetch master fills a DEPTH-entry FIFO of {pc, instr}
// pairs ahead of decode. Branch redirects flush the queue and discard any in-flight response.
module instruction_prefetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_branch_enable,
  input  logic [31:0] i_branch_address,
  input  logic        i_stall,
  wishbone_if.master  wishbone_bus,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_instruction_valid,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          cyc_q, cyc_d;
  logic [31:0]   adr_q, adr_d;

  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];

  logic          bus_ack;
  logic          push;
  logic          pop;
  logic [31:0]   branch_target;
  logic          unused_branch_low;

  // Redirect targets are word aligned; the low address bits carry no information.
  assign branch_target     = {i_branch_address[31:2], 2'b00};
  assign unused_branch_low = ^i_branch_address[1:0];

  assign bus_ack = wishbone_bus.ack && cyc_q;

  assign wishbone_bus.cyc = cyc_q;
  assign wishbone_bus.stb = cyc_q;
  assign wishbone_bus.we  = 1'b0;
  assign wishbone_bus.sel = 4'hF;
  assign wishbone_bus.adr = adr_q;

  assign o_instruction_valid = (count_q != '0);
  assign o_instruction       = o_instruction_valid ? ins_mem_q[rd_ptr_q] : NOP_INSTR;
  assign o_pc                = o_instruction_valid ? pc_mem_q[rd_ptr_q]  : RESET_PC;
  assign o_dbg_state         = state_q;

  // A redirect suppresses the pop so the stale head is never consumed.
  assign pop = o_instruction_valid && !i_stall && !i_branch_enable;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    push       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Issue uses the registered count: a pop this cycle frees space only for the next one.
        if (!i_branch_enable && (count_q < DEPTH_C)) begin
          state_d = ST_REQ;
          cyc_d   = 1'b1;
          adr_d   = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
          if (!i_branch_enable) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (i_branch_enable) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus_ack) begin
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    if (i_branch_enable) begin
      fetch_pc_d = branch_target;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_branch_enable) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
    end
  end

  // Queue storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
      ins_mem_q[wr_ptr_q] <= wishbone_bus.dat_r;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: table-driven cycle vectors plus hand-written sequences
// for delayed-ack redirect and mid-transaction reset.
module tb_instruction_prefetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [1:0]  S_IDL = 2'd0;
  localparam logic [1:0]  S_REQ = 2'd1;
  localparam logic [1:0]  S_DIS = 2'd2;

  typedef struct {
    logic        stall;
    logic        br_en;
    logic [31:0] br_addr;
    logic        exp_cyc;
    logic [31:0] exp_adr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    logic [1:0]  exp_state;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        br_en;
  logic [31:0] br_addr;
  logic        stall;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_valid;
  logic [1:0]  o_state;
  int unsigned ack_delay;
  logic [31:0] wait_q;

  int n_checks;
  int n_fail;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wishbone_if bus ();

  instruction_prefetch_unit #(
    .DEPTH     (4),
    .RESET_PC  (RPC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .i_branch_enable     (br_en),
    .i_branch_address    (br_addr),
    .i_stall             (stall),
    .wishbone_bus        (bus),
    .o_instruction       (o_instruction),
    .o_pc                (o_pc),
    .o_instruction_valid (o_valid),
    .o_dbg_state         (o_state)
  );

  // Slave model: mem[a] = a ^ A5A5_0000, ack after ack_delay wait cycles (0 = same cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (bus.cyc && bus.stb && !bus.ack) begin
      wait_q <= wait_q + 32'd1;
    end else begin
      wait_q <= '0;
    end
  end

  assign bus.ack   = bus.cyc && bus.stb && (wait_q >= ack_delay);
  assign bus.dat_r = bus.adr ^ 32'hA5A5_0000;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic st, input logic be, input logic [31:0] ba,
                             input logic cy, input logic [31:0] ad, input logic va,
                             input logic [31:0] pc, input logic [31:0] ins,
                             input logic [1:0] s);
    vec_t r;
    r.stall = st; r.br_en = be; r.br_addr = ba;
    r.exp_cyc = cy; r.exp_adr = ad; r.exp_valid = va;
    r.exp_pc = pc; r.exp_ins = ins; r.exp_state = s;
    return r;
  endfunction

  task automatic do_reset(input logic st);
    @(negedge clk);
    rst_n     = 1'b0;
    stall     = st;
    br_en     = 1'b0;
    br_addr   = '0;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    check("reset_cyc",   {31'd0, bus.cyc}, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_ins",   o_instruction,    NOP);
    check("reset_pc",    o_pc,             RPC);
    check("reset_state", {30'd0, o_state}, {30'd0, S_IDL});
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input string tag, input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      stall   = vecs[i].stall;
      br_en   = vecs[i].br_en;
      br_addr = vecs[i].br_addr;
      check($sformatf("%s[%0d].cyc", tag, i - first), {31'd0, bus.cyc}, {31'd0, vecs[i].exp_cyc});
      if (vecs[i].exp_cyc) begin
        check($sformatf("%s[%0d].adr", tag, i - first), bus.adr, vecs[i].exp_adr);
      end
      check($sformatf("%s[%0d].valid", tag, i - first), {31'd0, o_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("%s[%0d].pc", tag, i - first), o_pc, vecs[i].exp_pc);
      check($sformatf("%s[%0d].ins", tag, i - first), o_instruction, vecs[i].exp_ins);
      check($sformatf("%s[%0d].state", tag, i - first), {30'd0, o_state}, {30'd0, vecs[i].exp_state});
    end
    br_en = 1'b0;
    stall = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, b1, c1, d1;
    bit found;
    bit stale;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    br_en     = 1'b0;
    br_addr   = '0;
    ack_delay = 0;

    // Streaming with no stall, zero-wait slave.
    a0 = vecs.size();
    vecs.push_back(v(0, 0, 0, 1, 32'h0, 0, RPC,   NOP,          S_REQ));
    vecs.push_back(v(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000, S_IDL));
    vecs.push_back(v(0, 0, 0, 1, 32'h4, 0, RPC,   NOP,          S_REQ));
    vecs.push_back(v(0, 0, 0, 0, 32'h0, 1, 32'h4, 32'hA5A5_0004, S_IDL));
    vecs.push_back(v(0, 0, 0, 1, 32'h8, 0, RPC,   NOP,          S_REQ));
    vecs.push_back(v(0, 0, 0, 0, 32'h0, 1, 32'h8, 32'hA5A5_0008, S_IDL));
    a1 = vecs.size();
    // Stall from reset: fill to 4, no further issue, then drain on consecutive cycles.
    vecs.push_back(v(1, 0, 0, 1, 32'h0,  0, RPC,    NOP,           S_REQ));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,  1, 32'h0,  32'hA5A5_0000, S_IDL));
    vecs.push_back(v(1, 0, 0, 1, 32'h4,  1, 32'h0,  32'hA5A5_0000, S_REQ));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,  1, 32'h0,  32'hA5A5_0000, S_IDL));
    vecs.push_back(v(1, 0, 0, 1, 32'h8,  1, 32'h0,  32'hA5A5_0000, S_REQ));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,  1, 32'h0,  32'hA5A5_0000, S_IDL));
    vecs.push_back(v(1, 0, 0, 1, 32'hC,  1, 32'h0,  32'hA5A5_0000, S_REQ));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,  1, 32'h0,  32'hA5A5_0000, S_IDL));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,  1, 32'h0,  32'hA5A5_0000, S_IDL));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,  1, 32'h4,  32'hA5A5_0004, S_IDL));
    vecs.push_back(v(0, 0, 0, 1, 32'h10, 1, 32'h8,  32'hA5A5_0008, S_REQ));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,  1, 32'hC,  32'hA5A5_000C, S_IDL));
    vecs.push_back(v(0, 0, 0, 1, 32'h14, 1, 32'h10, 32'hA5A5_0010, S_REQ));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,  1, 32'h14, 32'hA5A5_0014, S_IDL));
    b1 = vecs.size();
    // Branch with ack and pop at count 2, then branch in IDLE to an unaligned target.
    vecs.push_back(v(1, 0, 0,           1, 32'h0,   0, RPC,     NOP,           S_REQ));
    vecs.push_back(v(1, 0, 0,           0, 32'h0,   1, 32'h0,   32'hA5A5_0000, S_IDL));
    vecs.push_back(v(1, 0, 0,           1, 32'h4,   1, 32'h0,   32'hA5A5_0000, S_REQ));
    vecs.push_back(v(1, 0, 0,           0, 32'h0,   1, 32'h0,   32'hA5A5_0000, S_IDL));
    vecs.push_back(v(0, 1, 32'h200,     1, 32'h8,   1, 32'h0,   32'hA5A5_0000, S_REQ));
    vecs.push_back(v(0, 0, 0,           0, 32'h0,   0, RPC,     NOP,           S_IDL));
    vecs.push_back(v(0, 0, 0,           1, 32'h200, 0, RPC,     NOP,           S_REQ));
    vecs.push_back(v(0, 1, 32'h303,     0, 32'h0,   1, 32'h200, 32'hA5A5_0200, S_IDL));
    vecs.push_back(v(0, 0, 0,           0, 32'h0,   0, RPC,     NOP,           S_IDL));
    vecs.push_back(v(0, 0, 0,           1, 32'h300, 0, RPC,     NOP,           S_REQ));
    vecs.push_back(v(0, 0, 0,           0, 32'h0,   1, 32'h300, 32'hA5A5_0300, S_IDL));
    c1 = vecs.size();
    // Fetch address wraps past the top of the address space.
    vecs.push_back(v(0, 1, 32'hFFFF_FFFC, 1, 32'h0,         0, RPC,           NOP,           S_REQ));
    vecs.push_back(v(0, 0, 0,             0, 32'h0,         0, RPC,           NOP,           S_IDL));
    vecs.push_back(v(0, 0, 0,             1, 32'hFFFF_FFFC, 0, RPC,           NOP,           S_REQ));
    vecs.push_back(v(0, 0, 0,             0, 32'h0,         1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, S_IDL));
    vecs.push_back(v(0, 0, 0,             1, 32'h0,         0, RPC,           NOP,           S_REQ));
    d1 = vecs.size();

    do_reset(1'b0);
    run_rows("stream", a0, a1);
    do_reset(1'b1);
    run_rows("stall", a1, b1);
    do_reset(1'b1);
    run_rows("br_ack", b1, c1);
    do_reset(1'b0);
    run_rows("wrap", c1, d1);

    // Redirect while REQ waits on a slow slave: response is dropped, fetch resumes at target.
    do_reset(1'b0);
    ack_delay = 3;
    @(negedge clk);
    check("disc.req_state", {30'd0, o_state}, {30'd0, S_REQ});
    br_en   = 1'b1;
    br_addr = 32'h0000_0102;
    @(negedge clk);
    br_en = 1'b0;
    check("disc.state", {30'd0, o_state}, {30'd0, S_DIS});
    check("disc.cyc_held", {31'd0, bus.cyc}, 32'd1);
    found = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (o_valid) stale = 1'b1;
      if (bus.cyc && o_state == S_REQ) found = 1'b1;
    end
    check("disc.reissue_seen", {31'd0, found}, 32'd1);
    check("disc.reissue_adr", bus.adr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (o_valid) found = 1'b1;
    end
    check("disc.no_stale", {31'd0, stale}, 32'd0);
    check("disc.valid_seen", {31'd0, found}, 32'd1);
    check("disc.first_pc", o_pc, 32'h0000_0100);
    check("disc.first_ins", o_instruction, 32'hA5A5_0100);

    // Reset asserted mid-REQ with two entries queued.
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    ack_delay = 3;
    check("rst_mid.pre_valid", {31'd0, o_valid}, 32'd1);
    @(negedge clk);
    check("rst_mid.pre_cyc", {31'd0, bus.cyc}, 32'd1);
    check("rst_mid.pre_state", {30'd0, o_state}, {30'd0, S_REQ});
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid.cyc", {31'd0, bus.cyc}, 32'd0);
    check("rst_mid.valid", {31'd0, o_valid}, 32'd0);
    check("rst_mid.ins", o_instruction, NOP);
    check("rst_mid.pc", o_pc, RPC);
    ack_delay = 0;
    stall     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.first_cyc", {31'd0, bus.cyc}, 32'd1);
    check("rst_mid.first_adr", bus.adr, RPC);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_prefetch_unit.md
Name: instruction_prefetch_unit

Overview:
Parametrised successor to the single-entry fetch stage in argon_riscv_cpu. It decouples instruction fetch from decode using a DEPTH-entry FIFO of {pc, instruction} pairs, so the Wishbone fetch master keeps prefetching sequential words while decode is stalled. Branch redirects from execution flush the queue and discard any in-flight bus response. It drives decode (instruction, pc) and the LSU (instruction_valid), and consumes stall from the LSU.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2.
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_INSTR, 32'h0000_0013, value driven on o_instruction while the queue is empty (addi x0,x0,0).

Ports:
clk  input  1  single clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset (reset==0 resets).
i_branch_enable  input  1  redirect request from execution.
i_branch_address  input  32  redirect target.
i_stall  input  1  high = decode/LSU cannot accept; head is held.
wishbone_bus  interface  wishbone_if.master  fetch bus; uses cyc, stb, we (tied 0), sel (tied 4'hF), adr, read data, ack.
o_instruction  output  32  head instruction.
o_pc  output  32  PC of head instruction.
o_instruction_valid  output  1  queue non-empty.

Behaviour:
- Reset (async assert, sync release): count=0, rd/wr ptr=0, fetch_pc=RESET_PC, state=IDLE, cyc=stb=0, adr=0, o_instruction_valid=0, o_instruction=NOP_INSTR, o_pc=RESET_PC. Reset mid-transaction drops cyc/stb immediately; no pending ack is honoured.
- Output side: o_instruction_valid = (count!=0). o_instruction/o_pc are the head entry (combinational from storage) when valid, else NOP_INSTR/RESET_PC. Pop when valid && !i_stall.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: if count<DEPTH and !i_branch_enable → REQ with cyc=stb=1 and adr=fetch_pc (registered, visible the next cycle).
  - REQ: hold cyc/stb/adr until ack. On ack: push {fetch_pc, data}, fetch_pc+=4, cyc=stb=0, → IDLE. Space is guaranteed because count<DEPTH at issue and only pops can occur while waiting.
  - DISCARD: hold cyc/stb until ack, then drop the data, deassert, → IDLE. No push.
- Throughput: one word per two cycles minimum (issue cycle plus ack cycle with a zero-wait slave). An entry pushed on the ack edge is valid from the next cycle.
- Branch (i_branch_enable=1), highest priority:
  - On the next edge: count=0, ptrs=0, fetch_pc={i_branch_address[31:2],2'b00}.
  - Any pop or push in the same cycle is suppressed.
  - REQ without ack in the same cycle → DISCARD. REQ with ack in the same cycle → data dropped, → IDLE.
  - IDLE → stays IDLE for this cycle; fetch starts the following cycle.
  - Branch while in DISCARD: stays DISCARD, fetch_pc is updated.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==DEPTH): no new request is issued; a pop in the same cycle does not enable issue until the next cycle.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide. fetch_pc wraps modulo 2^32.
- we=0 always; bus error is not supported (slave must ack).

Test Plan:
- Reset release, zero-wait slave returning mem[a]=a^32'hA5A5_0000, i_stall=0 → adr sequence 0,4,8,…; o_pc=0 with o_instruction=32'hA5A5_0000 valid exactly one cycle after the first ack.
- i_stall=1 held, DEPTH=4 → exactly 4 acks, cyc stays 0 afterwards, head stays pc=0. Release stall → pcs 0,4,8,12 pop on consecutive cycles and fetching resumes at 16.
- Branch to 32'h0000_0102 while in REQ, slave ack delayed 3 cycles → state DISCARD, the stale word never appears, next adr=32'h0000_0100, first valid o_pc=32'h100.
- Branch in the same cycle as ack and pop with count=2 → count=0 next cycle, valid=0, next fetch adr is the branch target.
- Assert reset low mid-REQ with 2 entries queued → immediately cyc=0, valid=0, o_instruction=32'h13. After release, first adr=RESET_PC.
- fetch_pc=32'hFFFF_FFFC fetched → next adr=32'h0000_0000 (wrap).
